// File: rtl/instr_encoder.sv
// Packs RV32I fields plus an immediate into an instruction word; 2-stage valid/ready pipeline.
// Latency 2 cycles accept-to-out_valid, 1 beat/cycle; S2 holds on !out_ready, S1 holds when full.
module instr_encoder #(
  parameter int          ERR_CNT_W = 8,
  parameter logic [31:0] ERR_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_fmt,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [2:0]           in_funct3,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [6:0]           in_funct7,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_J = 3'b011;
  localparam logic [2:0] FMT_R = 3'b100;
  localparam logic [2:0] FMT_U = 3'b101;

  logic                 rst_done_q, rst_done_d;
  logic                 s1_valid_q, s1_valid_d;
  logic [2:0]           s1_fmt_q, s1_fmt_d;
  logic [6:0]           s1_op_q, s1_op_d;
  logic [4:0]           s1_rd_q, s1_rd_d;
  logic [2:0]           s1_f3_q, s1_f3_d;
  logic [4:0]           s1_rs1_q, s1_rs1_d;
  logic [4:0]           s1_rs2_q, s1_rs2_d;
  logic [6:0]           s1_f7_q, s1_f7_d;
  logic [31:0]          s1_imm_q, s1_imm_d;
  logic                 s1_err_q, s1_err_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [31:0]          out_instr_q, out_instr_d;
  logic                 out_err_q, out_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic        imm_ok;
  logic        s2_ready;
  logic        in_fire;
  logic [31:0] packed_word;

  // Immediate must be representable in the target format's encoded field.
  always_comb begin
    imm_ok = 1'b0;
    case (in_fmt)
      FMT_I, FMT_S: imm_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
      FMT_B:        imm_ok = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
      FMT_J:        imm_ok = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
      FMT_U:        imm_ok = (in_imm[11:0] == 12'd0);
      FMT_R:        imm_ok = 1'b1;
      default:      imm_ok = 1'b0;
    endcase
  end

  always_comb begin
    packed_word = ERR_INSTR;
    if (!s1_err_q) begin
      case (s1_fmt_q)
        FMT_R: packed_word = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
        FMT_I: packed_word = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
        FMT_S: packed_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                              s1_imm_q[4:0], s1_op_q};
        FMT_B: packed_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                              s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
        FMT_U: packed_word = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
        FMT_J: packed_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                              s1_rd_q, s1_op_q};
        default: packed_word = ERR_INSTR;
      endcase
    end
  end

  assign s2_ready = !s2_valid_q || out_ready;
  // rst_done_q keeps in_ready low until the first edge after reset release.
  assign in_ready = rst_done_q && (!s1_valid_q || s2_ready);
  assign in_fire  = in_valid && in_ready && !flush;

  always_comb begin
    rst_done_d  = 1'b1;
    s1_valid_d  = s1_valid_q;
    s1_fmt_d    = s1_fmt_q;
    s1_op_d     = s1_op_q;
    s1_rd_d     = s1_rd_q;
    s1_f3_d     = s1_f3_q;
    s1_rs1_d    = s1_rs1_q;
    s1_rs2_d    = s1_rs2_q;
    s1_f7_d     = s1_f7_q;
    s1_imm_d    = s1_imm_q;
    s1_err_d    = s1_err_q;
    s2_valid_d  = s2_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;

    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_instr_d = packed_word;
        out_err_d   = s1_err_q;
      end
    end
    if (!s1_valid_q || s2_ready) s1_valid_d = in_fire;
    if (in_fire) begin
      s1_fmt_d = in_fmt;
      s1_op_d  = in_opcode;
      s1_rd_d  = in_rd;
      s1_f3_d  = in_funct3;
      s1_rs1_d = in_rs1;
      s1_rs2_d = in_rs2;
      s1_f7_d  = in_funct7;
      s1_imm_d = in_imm;
      s1_err_d = !imm_ok;
    end
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end

    // Counted only when the rejected beat is actually handed over.
    if (s2_valid_q && out_ready && out_err_q && (err_cnt_q != {ERR_CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_fmt_q    <= 3'd0;
      s1_op_q     <= 7'd0;
      s1_rd_q     <= 5'd0;
      s1_f3_q     <= 3'd0;
      s1_rs1_q    <= 5'd0;
      s1_rs2_q    <= 5'd0;
      s1_f7_q     <= 7'd0;
      s1_imm_q    <= 32'd0;
      s1_err_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_instr_q <= 32'd0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      rst_done_q  <= rst_done_d;
      s1_valid_q  <= s1_valid_d;
      s1_fmt_q    <= s1_fmt_d;
      s1_op_q     <= s1_op_d;
      s1_rd_q     <= s1_rd_d;
      s1_f3_q     <= s1_f3_d;
      s1_rs1_q    <= s1_rs1_d;
      s1_rs2_q    <= s1_rs2_d;
      s1_f7_q     <= s1_f7_d;
      s1_imm_q    <= s1_imm_d;
      s1_err_q    <= s1_err_d;
      s2_valid_q  <= s2_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: latency, packing, range errors, stalls, flush, reset, saturation.
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_instr;
  logic [7:0]  err_cnt;
  logic        sat_in_ready, sat_out_valid, sat_out_err;
  logic [31:0] sat_out_instr;
  logic [1:0]  sat_err_cnt;

  int compared   = 0;
  int mismatched = 0;
  int exp_cnt    = 0;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .err_cnt(err_cnt)
  );

  instr_encoder #(.ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_instr(sat_out_instr),
    .out_err(sat_out_err), .err_cnt(sat_err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    compared++;
    mismatched++;
    $error("FAIL %s: handshake did not occur within cycle budget", tag);
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_funct3 = f3;
    in_rs1 = r1; in_rs2 = r2; in_funct7 = f7; in_imm = imm;
    in_valid = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input string tag, input logic [2:0] f, input logic [6:0] op,
                      input logic [4:0] rd, input logic [2:0] f3, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [6:0] f7, input logic [31:0] imm);
    int n = 0;
    drive(f, op, rd, f3, r1, r2, f7, imm);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) timeout(tag);
    else begin @(posedge clk); @(negedge clk); end
    in_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [31:0] ei, input logic ee);
    int n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    if (!out_valid) timeout(tag);
    else begin
      chk({tag, "_instr"}, out_instr, ei);
      chk({tag, "_err"}, 32'(out_err), 32'(ee));
      chk({tag, "_cnt_pre"}, 32'(err_cnt), 32'(exp_cnt));
      @(posedge clk); @(negedge clk);
      if (ee) exp_cnt++;
      chk({tag, "_cnt"}, 32'(err_cnt), 32'(exp_cnt));
    end
  endtask

  // Reference immediate extender used for the round-trip check.
  function automatic logic [31:0] ext(input logic [2:0] f, input logic [31:0] w);
    case (f)
      3'd0:    return {{20{w[31]}}, w[31:20]};
      3'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  initial begin
    logic [2:0]  rf;
    logic [31:0] rr, rimm, exp_w;
    int acc, got, occ, n;
    logic hs_in, hs_out;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(3'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sat_in_ready", 32'(sat_in_ready), 32'd1);
    chk("rst_sat_out", {sat_out_instr[29:0], sat_out_valid, sat_out_err}, 32'd0);

    // addi x5,x6,-1 with exact latency
    out_ready = 1'b1;
    drive(3'd0, 7'h13, 5'd5, 3'd0, 5'd6, 5'd0, 7'd0, 32'hFFFF_FFFF);
    chk("addi_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("addi_lat1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("addi_lat2_valid", 32'(out_valid), 32'd1);
    chk("addi_instr", out_instr, 32'hFFF3_0293);
    chk("addi_err", 32'(out_err), 32'd0);
    @(negedge clk);
    chk("addi_drained", 32'(out_valid), 32'd0);

    send("beq", 3'd2, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFF_FFFC);
    recv("beq", 32'hFE20_8EE3, 1'b0);
    send("b_odd", 3'd2, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd3);
    recv("b_odd", 32'h0000_0013, 1'b1);
    send("jal", 3'd3, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
    recv("jal", 32'h0010_00EF, 1'b0);
    send("add", 3'd4, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'hDEAD_BEEF);
    recv("add", 32'h0020_81B3, 1'b0);
    send("lui", 3'd5, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000);
    recv("lui", 32'h1234_52B7, 1'b0);
    send("sw", 3'd1, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8);
    recv("sw", 32'h0020_A423, 1'b0);
    send("i_min", 3'd0, 7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0, 32'hFFFF_F800);
    recv("i_min", 32'h8001_0093, 1'b0);
    send("i_2048", 3'd0, 7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0, 32'd2048);
    recv("i_2048", 32'h0000_0013, 1'b1);
    send("u_low", 3'd5, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0000_1001);
    recv("u_low", 32'h0000_0013, 1'b1);
    send("fmt110", 3'd6, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    recv("fmt110", 32'h0000_0013, 1'b1);

    // Round trip of random legal I/S/B/J immediates
    for (int k = 0; k < 2000; k++) begin
      rf = 3'($urandom_range(0, 3));
      rr = $urandom;
      case (rf)
        3'd0, 3'd1: rimm = {{20{rr[11]}}, rr[11:0]};
        3'd2:       rimm = {{19{rr[12]}}, rr[12:1], 1'b0};
        default:    rimm = {{11{rr[20]}}, rr[20:1], 1'b0};
      endcase
      send("rt_send", rf, 7'($urandom), 5'($urandom), 3'($urandom), 5'($urandom),
           5'($urandom), 7'($urandom), rimm);
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      if (!out_valid) timeout("rt_recv");
      else chk("round_trip", ext(rf, out_instr), rimm);
      @(negedge clk);
    end

    // Back-to-back 8 beats, out_ready toggling 1,0,1,0...
    acc = 0; got = 0; occ = 0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      out_ready = (cyc % 2 == 0);
      if (acc < 8) drive(3'd0, 7'h13, 5'(acc), 3'd0, 5'd0, 5'd0, 7'd0, 32'(acc));
      else in_valid = 1'b0;
      #1;
      chk("b2b_in_ready", 32'(in_ready), 32'(!(occ == 2 && !out_ready)));
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      if (hs_out) begin
        exp_w = {12'(got), 5'd0, 3'd0, 5'(got), 7'h13};
        chk("b2b_order", out_instr, exp_w);
        got++;
      end
      if (hs_in) acc++;
      occ = occ + (hs_in ? 1 : 0) - (hs_out ? 1 : 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_count", 32'(got), 32'd8);

    // Flush with both stages full; the error beat in S1 must never be counted
    out_ready = 1'b0;
    drive(3'd4, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
    @(negedge clk);
    drive(3'd6, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_err_cnt", 32'(err_cnt), 32'(exp_cnt));
    out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("flush_no_resurface", 32'(out_valid), 32'd0);
    chk("flush_err_cnt_after", 32'(err_cnt), 32'(exp_cnt));

    // Input accepted in a flush cycle is discarded
    flush = 1'b1;
    drive(3'd0, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_in_drop1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("flush_in_drop2", 32'(out_valid), 32'd0);

    // Reset mid-stream with an error beat waiting at the output
    out_ready = 1'b0;
    send("rst_beat", 3'd7, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_err", 32'(out_err), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_instr", out_instr, 32'd0);
    chk("arst_out_err", 32'(out_err), 32'd0);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rerst_in_ready", 32'(in_ready), 32'd1);
    chk("rerst_no_output", 32'(out_valid), 32'd0);

    // Saturation of a 2-bit counter after 5 rejected beats
    for (int k = 0; k < 5; k++) begin
      send("sat_send", 3'd7, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
      recv("sat", 32'h0000_0013, 1'b1);
    end
    chk("sat_err_cnt", 32'(sat_err_cnt), 32'd3);
    chk("wide_err_cnt", 32'(err_cnt), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
